// File: rtl/muldiv_seq_pkg.sv
// Shared CPU package (cpu_pkg) used by the EX-stage blocks.
// Contents:
//   - funct3 encodings of the RV32M operations (MULDIV_MUL .. MULDIV_REMU)
//   - FSM state type of the multiply/divide sequencer
//   - the 4-bit single-cycle ALU operation encoding, kept here for decode
//   - small decode helpers for operand signedness
package cpu_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_t;

  // funct3[2] separates the divide/remainder group from the multiply group.
  function automatic logic muldiv_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic muldiv_a_signed(input logic [2:0] op);
    return (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
           (op == MULDIV_DIV)  || (op == MULDIV_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic muldiv_b_signed(input logic [2:0] op);
    return (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
// master = EX stage (requester), slave = muldiv_seq.
//   flush      master->slave  abort the op in flight
//   in_valid   master->slave  op request
//   in_ready   slave->master  sequencer idle and able to accept
//   in_op      master->slave  funct3 of the M-extension op
//   in_a/in_b  master->slave  rs1/rs2 operands
//   out_valid  slave->master  result valid, held until accepted
//   out_ready  master->slave  result accepted
//   out_result slave->master  32-bit result
//   busy       slave->master  stall request for EX
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/muldiv_divstep.sv
// One restoring-divide step, purely combinational.
//   rem      in   XLEN  partial remainder (always < dvs)
//   dvd_msb  in   1     next dividend bit shifted into the remainder
//   dvs      in   XLEN  divisor magnitude (non-zero)
//   rem_next out  XLEN  partial remainder after this step
//   q_bit    out  1     quotient bit produced by this step
module muldiv_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem, dvd_msb};
    diff    = shifted - {1'b0, dvs};
    // Because rem < dvs, shifted < 2*dvs: a non-negative difference always
    // fits in XLEN bits, so the top bit of the (XLEN+1)-bit difference is
    // exactly the borrow.
    q_bit    = ~diff[XLEN];
    rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer sitting beside the EX-stage ALU.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
//   IDLE -(accept)-> PREP -> CALC (XLEN cycles) -> FIX -> DONE -(out_ready)-> IDLE
//   Divide by zero skips straight from PREP to DONE.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    muldiv_seq_if.slave (flush, request, response and busy signals)
// Build option:
//   MULDIV_EARLY_EXIT_EN  multiply CALC stops once the remaining multiplier
//                         is zero; divide always runs XLEN steps.
module muldiv_seq
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;

  muldiv_state_t state_reg, state_next;

  logic [2:0]        op_reg;
  logic [XLEN-1:0]   a_reg, b_reg;
  logic [CW-1:0]     cnt_reg;
  logic [2*XLEN-1:0] acc_reg, mcand_reg;
  logic [XLEN-1:0]   mplier_reg;
  logic [XLEN-1:0]   rem_reg, quo_reg, dvs_reg;
  logic              neg_res_reg, neg_rem_reg;
  logic [XLEN-1:0]   result_reg;

  logic              accept;
  logic              op_is_div, div_by_zero;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   mplier_shr;
  logic              calc_done;
  logic [XLEN-1:0]   rem_step;
  logic              q_step;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient, remainder, fix_result;

  muldiv_divstep #(.XLEN(XLEN)) u_divstep (
    .rem      (rem_reg),
    .dvd_msb  (quo_reg[XLEN-1]),
    .dvs      (dvs_reg),
    .rem_next (rem_step),
    .q_bit    (q_step)
  );

  // Operand decode on the latched request.
  always_comb begin
    op_is_div   = muldiv_is_div(op_reg);
    div_by_zero = op_is_div && (b_reg == '0);
    sign_a      = muldiv_a_signed(op_reg) && a_reg[XLEN-1];
    sign_b      = muldiv_b_signed(op_reg) && b_reg[XLEN-1];
    mag_a       = sign_a ? -a_reg : a_reg;
    mag_b       = sign_b ? -b_reg : b_reg;
    mplier_shr  = mplier_reg >> 1;
  end

  // Sign correction and result selection for FIX.
  always_comb begin
    product    = neg_res_reg ? -acc_reg : acc_reg;
    quotient   = neg_res_reg ? -quo_reg : quo_reg;
    remainder  = neg_rem_reg ? -rem_reg : rem_reg;
    fix_result = '0;
    case (op_reg)
      MULDIV_MUL:                             fix_result = product[XLEN-1:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: fix_result = product[2*XLEN-1:XLEN];
      MULDIV_DIV, MULDIV_DIVU:                fix_result = quotient;
      default:                                fix_result = remainder;
    endcase
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    calc_done  = (cnt_reg == CW'(XLEN - 1));
`ifdef MULDIV_EARLY_EXIT_EN
    // Nothing left to add once the shifted-out multiplier is zero.
    if (!op_is_div && (mplier_shr == '0)) begin
      calc_done = 1'b1;
    end
`endif
    accept = bus.in_valid && (state_reg == IDLE) && !bus.flush;

    case (state_reg)
      IDLE:    if (accept) state_next = PREP;
      PREP:    state_next = div_by_zero ? DONE : CALC;
      CALC:    if (calc_done) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A kill from the pipeline overrides everything, including the
    // consumer taking the result.
    if (bus.flush) begin
      state_next = IDLE;
    end

    bus.in_ready   = (state_reg == IDLE);
    bus.out_valid  = (state_reg == DONE);
    bus.busy       = (state_reg != IDLE);
    bus.out_result = result_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_reg  <= '0;
    end else if (!bus.flush) begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg <= bus.in_op;
            a_reg  <= bus.in_a;
            b_reg  <= bus.in_b;
          end
        end
        PREP: begin
          cnt_reg     <= '0;
          neg_res_reg <= sign_a ^ sign_b;
          neg_rem_reg <= sign_a;
          acc_reg     <= '0;
          mcand_reg   <= {{XLEN{1'b0}}, mag_a};
          mplier_reg  <= mag_b;
          rem_reg     <= '0;
          quo_reg     <= mag_a;
          dvs_reg     <= mag_b;
          if (div_by_zero) begin
            result_reg <= ((op_reg == MULDIV_DIV) || (op_reg == MULDIV_DIVU)) ? '1 : a_reg;
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (op_is_div) begin
            // quo_reg shifts the dividend out at the top while the quotient
            // bits fill in from the bottom.
            rem_reg <= rem_step;
            quo_reg <= {quo_reg[XLEN-2:0], q_step};
          end else begin
            if (mplier_reg[0]) begin
              acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_shr;
          end
        end
        FIX: begin
          result_reg <= fix_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
module tb_muldiv_seq;
  import cpu_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = {32'h0, b};
    case (op)
      MULDIV_MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0];  end
      MULDIV_MULH:   begin p = sa * sb;                  return p[63:32]; end
      MULDIV_MULHSU: begin p = sa * ub;                  return p[63:32]; end
      MULDIV_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      MULDIV_DIV:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      MULDIV_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MULDIV_REM:    return (b == 0) ? a : 32'(sa % sb);
      default:       return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the accepting edge to the first edge that can take the result.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
    logic [31:0] m;
    int          n;
    if (op[2]) return (b == 0) ? 2 : XLEN + 3;
    m = (op == MULDIV_MULH && b[31]) ? -b : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n + 3;
`else
    if (op[2] && b == 0) return 2;
    return XLEN + 3;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: in_ready=0 after 100 cycles, expected 1");
    end
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    // Scramble the operands after the accept; the op must not notice.
    bus.in_valid = 1'b0;
    bus.in_op    = 3'($urandom);
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
  endtask

  task automatic wait_result(output int lat, output logic [31:0] res, output bit got);
    lat = 0;
    res = '0;
    got = 1'b0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        lat = c;
        res = bus.out_result;
      end
    end
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int delay);
    int          lat;
    logic [31:0] res;
    bit          got;
    issue(op, a, b);
    wait_result(lat, res, got);
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid=0 after 100 cycles, expected 1", name);
    end else begin
      check({name, "_result"}, res, exp);
      check({name, "_latency"}, 32'(lat), 32'(ref_latency(op, b)));
      repeat (delay) @(negedge clk);
      check({name, "_hold"}, bus.out_result, exp);
      take_result();
    end
    $display("txn %s op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d",
             name, op, a, b, res, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          seen;
    logic [31:0] res;
    bit          got;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    vecs.push_back(vec_t'{MULDIV_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back(vec_t'{MULDIV_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF});
    vecs.push_back(vec_t'{MULDIV_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back(vec_t'{MULDIV_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back(vec_t'{MULDIV_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    vecs.push_back(vec_t'{MULDIV_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back(vec_t'{MULDIV_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back(vec_t'{MULDIV_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0});
    vecs.push_back(vec_t'{MULDIV_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back(vec_t'{MULDIV_REMU,   32'd5,          32'd0,         32'd5});
    vecs.push_back(vec_t'{MULDIV_DIV,    32'd7,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back(vec_t'{MULDIV_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9});
    vecs.push_back(vec_t'{MULDIV_MUL,    32'd5,          32'd1,         32'd5});
    vecs.push_back(vec_t'{MULDIV_MULHU,  32'h8000_0000,  32'd2,         32'd1});
    vecs.push_back(vec_t'{MULDIV_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
    vecs.push_back(vec_t'{MULDIV_DIVU,   32'd100,        32'd7,         32'd14});
    vecs.push_back(vec_t'{MULDIV_REMU,   32'd100,        32'd7,         32'd2});
    vecs.push_back(vec_t'{MULDIV_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD});
    vecs.push_back(vec_t'{MULDIV_REM,    32'd7,          32'hFFFF_FFFE, 32'd1});

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_out_result", bus.out_result, 32'd0);
    rst_n = 1'b1;

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
    end

    // Result held for 10 cycles while a new request waits.
    issue(MULDIV_MUL, 32'd6, 32'd7);
    wait_result(lat, res, got);
    check("hold_got", 32'(got), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = MULDIV_MUL;
    bus.in_a     = 32'd1;
    bus.in_b     = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_out_result", bus.out_result, 32'd42);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    take_result();
    @(negedge clk);
    check("after_take_out_valid", 32'(bus.out_valid), 32'd0);
    check("after_take_busy", 32'(bus.busy), 32'd0);
    $display("txn hold MUL 6x7 result=0x%08h", res);

    // Flush at CALC cnt=10, then no result may appear.
    issue(MULDIV_MUL, 32'd9, 32'd9);
    repeat (11) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    $display("txn flush MUL 9x9 killed at cnt=10");
    run_op("post_flush", MULDIV_MUL, 32'd3, 32'd4, 32'd12, 0);

    // flush together with a request in IDLE: not accepted.
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = MULDIV_MUL;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 32'(bus.busy), 32'd0);
    $display("txn flush with in_valid in IDLE");

    // Asynchronous reset mid-CALC.
    issue(MULDIV_MULHU, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_out_result", bus.out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn async reset during CALC");
    run_op("post_reset", MULDIV_DIV, 32'd100, 32'd7, 32'd14, 0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op($sformatf("rnd%0d", i), rop, ra, rb, ref_result(rop, ra, rb), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
